// File: rtl/led_pwm_driver_param_if.sv
// led_pwm_driver_param_if: panel data link in, column/line drive out.
// master = link/test side, slave = driver.
interface led_pwm_driver_param_if #(
  parameter int CH      = 16,
  parameter int GS_BITS = 8,
  parameter int SCAN    = 8
);
  localparam int LW = (SCAN > 1) ? $clog2(SCAN) : 1;

  logic               din;
  logic               den;
  logic               vsync;
  logic [GS_BITS-1:0] bright;
  logic [CH-1:0]      out;
  logic [LW-1:0]      line_sel;
  logic               line_valid;
  logic               frame_ready;
  logic               frame_done;
  logic               overflow;

  modport master (
    output din, den, vsync, bright,
    input  out, line_sel, line_valid,
    input  frame_ready, frame_done, overflow
  );

  modport slave (
    input  din, den, vsync, bright,
    output out, line_sel, line_valid,
    output frame_ready, frame_done, overflow
  );
endinterface

// File: rtl/led_pwm_driver_param.sv
// led_pwm_driver_param: multiplexed LED PWM driver, double-buffered frame.
// Macro LED_PWM_SCRAMBLE_EN: bit-reversed PWM compare spreads pulses.
module led_pwm_driver_param #(
  parameter int CH      = 16,
  parameter int GS_BITS = 8,
  parameter int SCAN    = 8,
  parameter int BLANK   = 2
) (
  input logic clk,
  input logic rst,
  led_pwm_driver_param_if.slave bus
);
  localparam int LW    = (SCAN > 1) ? $clog2(SCAN) : 1;
  localparam int WORDS = CH * SCAN;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW    = $clog2(BLANK + 1);
  localparam int PW    = 2 * GS_BITS + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PWM   = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  logic [1:0]         state;
  logic [GS_BITS-1:0] bank [2][WORDS];
  logic [GS_BITS-1:0] sreg;
  logic               den_d;
  logic               vsync_d;
  logic               bank_sel;
  logic               frame_ready;
  logic               overflow;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      base;
  logic [GS_BITS-1:0] bright_q;
  logic [GS_BITS-1:0] cnt;
  logic [GS_BITS-1:0] cmp_cnt;
  logic [GS_BITS-1:0] eff [CH];
  logic [LW-1:0]      line;
  logic [LW-1:0]      line_sel;
  logic [BW-1:0]      bcnt;
  logic [CH-1:0]      out_q;
  logic               line_valid;
  logic               frame_done;
  logic               den_fall;
  logic               vs_rise;
  logic               swap;

  function automatic logic [GS_BITS-1:0] scale(
    input logic [GS_BITS-1:0] p,
    input logic [GS_BITS-1:0] b
  );
    logic [PW-1:0] prod;
    prod = PW'(p) * (PW'(b) + PW'(1));
    return prod[2*GS_BITS-1:GS_BITS];
  endfunction

  assign den_fall = den_d & ~bus.den;
  assign vs_rise  = bus.vsync & ~vsync_d;
  assign swap     = (state == S_IDLE) & vs_rise & frame_ready;
  assign base     = AW'(line) * AW'(CH);

`ifdef LED_PWM_SCRAMBLE_EN
  // Bit-reversed counter: same on-count, pulses spread over the period
  always_comb begin
    cmp_cnt = '0;
    for (int i = 0; i < GS_BITS; i++)
      cmp_cnt[i] = cnt[GS_BITS-1-i];
  end
`else
  assign cmp_cnt = cnt;
`endif

  // Serial capture into the back bank; full back bank waits for a swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg        <= '0;
      den_d       <= 1'b0;
      wptr        <= '0;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      bank_sel    <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < WORDS; w++)
          bank[b][w] <= '0;
    end else begin
      den_d    <= bus.den;
      overflow <= 1'b0;
      if (bus.den)
        sreg <= {bus.din, sreg[GS_BITS-1:1]};
      if (swap) begin
        bank_sel    <= ~bank_sel;
        frame_ready <= 1'b0;
      end
      if (den_fall) begin
        if (frame_ready) begin
          overflow <= 1'b1;
        end else begin
          bank[~bank_sel][wptr] <= sreg;
          if (wptr == AW'(WORDS - 1)) begin
            wptr        <= '0;
            frame_ready <= 1'b1;
          end else begin
            wptr <= wptr + AW'(1);
          end
        end
      end
    end
  end

  // Display sequencer: LOAD scales a line, PWM drives it, BLANK gaps it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vsync_d    <= 1'b0;
      bright_q   <= '0;
      line       <= '0;
      line_sel   <= '0;
      cnt        <= '0;
      bcnt       <= '0;
      out_q      <= '0;
      line_valid <= 1'b0;
      frame_done <= 1'b0;
      for (int c = 0; c < CH; c++)
        eff[c] <= '0;
    end else begin
      vsync_d    <= bus.vsync;
      frame_done <= 1'b0;
      out_q      <= '0;
      line_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (vs_rise) begin
            bright_q <= bus.bright;
            line     <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          line_sel <= line;
          for (int c = 0; c < CH; c++)
            eff[c] <= scale(bank[bank_sel][base + AW'(c)], bright_q);
          cnt   <= '0;
          state <= S_PWM;
        end
        S_PWM: begin
          line_valid <= 1'b1;
          for (int c = 0; c < CH; c++)
            out_q[c] <= (cmp_cnt < eff[c]);
          cnt <= cnt + GS_BITS'(1);
          if (cnt == '1) begin
            bcnt  <= '0;
            state <= S_BLANK;
          end
        end
        S_BLANK: begin
          bcnt <= bcnt + BW'(1);
          if (bcnt == BW'(BLANK - 1)) begin
            if (line == LW'(SCAN - 1)) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              line  <= line + LW'(1);
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.line_sel    = line_sel;
  assign bus.line_valid  = line_valid;
  assign bus.frame_ready = frame_ready;
  assign bus.frame_done  = frame_done;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_led_pwm_driver_param.sv
// tb_led_pwm_driver_param: random frames vs a frame-level reference model.
// Expected lines are queued at vsync; a monitor checks each displayed line.
module tb_led_pwm_driver_param;
  localparam int CH    = 4;
  localparam int G     = 4;
  localparam int SCAN  = 2;
  localparam int BLANK = 2;
  localparam int P     = 1 << G;
  localparam int WORDS = CH * SCAN;
  localparam int LP    = 1 + P + BLANK;

  typedef struct packed {
    int                  line;
    logic [CH-1:0][P-1:0] pat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_pwm_driver_param_if #(.CH(CH), .GS_BITS(G), .SCAN(SCAN)) bus();

  led_pwm_driver_param #(
    .CH(CH), .GS_BITS(G), .SCAN(SCAN), .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q[$];

  int front [WORDS];
  int back  [WORDS];
  int wcnt;
  bit ready;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [P-1:0] pat_of(input int eff);
    logic [P-1:0] p;
    p = '0;
    for (int k = 0; k < P; k++) begin
      int pos;
      pos = k;
`ifdef LED_PWM_SCRAMBLE_EN
      pos = 0;
      for (int b = 0; b < G; b++)
        if ((k >> b) & 1) pos = pos | (1 << (G - 1 - b));
`endif
      p[k] = (pos < eff);
    end
    return p;
  endfunction

  // Monitor: collect one line_valid window, then compare with the queue head
  logic [CH-1:0][P-1:0] cap;
  int idx;
  int cur_line;
  bit in_line = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      in_line = 1'b0;
      idx     = 0;
    end else if (bus.line_valid) begin
      if (!in_line) begin
        in_line  = 1'b1;
        idx      = 0;
        cur_line = int'(bus.line_sel);
        cap      = '0;
      end
      if (idx < P)
        for (int c = 0; c < CH; c++) cap[c][idx] = bus.out[c];
      idx++;
    end else begin
      check("out_dark", bus.out, 0);
      if (in_line) begin
        exp_t e;
        in_line = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_line", 1, 0);
        end else begin
          e = q.pop_front();
          check("line_sel", cur_line, e.line);
          check("pwm_len", idx, P);
          for (int c = 0; c < CH; c++)
            check($sformatf("pat_l%0d_c%0d", e.line, c), cap[c], e.pat[c]);
        end
      end
    end
  end

  task automatic model_clear();
    for (int w = 0; w < WORDS; w++) begin
      front[w] = 0;
      back[w]  = 0;
    end
    wcnt  = 0;
    ready = 1'b0;
  endtask

  task automatic send_word(input int v);
    bit exp_ovf;
    for (int i = 0; i < G; i++) begin
      @(negedge clk);
      bus.den = 1'b1;
      bus.din = 1'((v >> i) & 1);
    end
    @(negedge clk);
    bus.den = 1'b0;
    bus.din = 1'b0;
    exp_ovf = ready;
    if (!ready) begin
      back[wcnt] = v;
      wcnt++;
      if (wcnt == WORDS) begin
        wcnt  = 0;
        ready = 1'b1;
      end
    end
    @(negedge clk);
    check("overflow", bus.overflow, exp_ovf);
    check("frame_ready", bus.frame_ready, ready);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.den   = 1'b0;
    bus.vsync = 1'b0;
    #1;
    check("rst_out", bus.out, 0);
    check("rst_line_valid", bus.line_valid, 0);
    check("rst_line_sel", bus.line_sel, 0);
    check("rst_frame_ready", bus.frame_ready, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overflow", bus.overflow, 0);
    q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int br, input bit vs_mid,
                           input int abort_at);
    int   n;
    bit   done;
    exp_t e;
    if (ready) begin
      front = back;
      ready = 1'b0;
    end
    for (int l = 0; l < SCAN; l++) begin
      e.line = l;
      for (int c = 0; c < CH; c++)
        e.pat[c] = pat_of((front[l*CH+c] * (br + 1)) >> G);
      q.push_back(e);
    end
    @(negedge clk);
    bus.bright = G'(br);
    bus.vsync  = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) check("ready_after_vsync", bus.frame_ready, ready);
      if (n == 2) bus.vsync = 1'b0;
      if (vs_mid && n == 8) bus.vsync = 1'b1;
      if (vs_mid && n == 10) bus.vsync = 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        do_reset();
        return;
      end
      if (bus.frame_done) done = 1'b1;
    end
    check("frame_done_seen", done, 1);
    check("frame_len", n, SCAN * LP + 1);
    @(negedge clk);
    check("frame_done_pulse", bus.frame_done, 0);
    check("lines_left", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.din    = 1'b0;
    bus.den    = 1'b0;
    bus.vsync  = 1'b0;
    bus.bright = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("init_out", bus.out, 0);
    check("init_frame_ready", bus.frame_ready, 0);
    check("init_line_valid", bus.line_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int w = 0; w < WORDS; w++) send_word($urandom_range(0, P - 1));
    run_frame(15, 1'b0, 10);
    for (int w = 0; w < 3; w++) send_word($urandom_range(0, P - 1));
    do_reset();
    run_frame($urandom_range(0, P - 1), 1'b0, 0);

    for (int w = 0; w < WORDS; w++) send_word(w == 0 ? 5 : 0);
    run_frame(15, 1'b0, 0);

    for (int w = 0; w < WORDS; w++)
      send_word(w < CH ? 15 : $urandom_range(0, P - 1));
    run_frame(7, 1'b0, 0);
    run_frame(0, 1'b1, 0);

    for (int w = 0; w < WORDS; w++) send_word(w == 1 ? 8 : 15);
    send_word(3);
    run_frame(3, 1'b0, 0);
    run_frame(15, 1'b1, 0);

    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(0, WORDS + 2);
      for (int w = 0; w < nw; w++) send_word($urandom_range(0, P - 1));
      run_frame($urandom_range(0, P - 1), 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
